// File: rtl/rv_pkg.sv
// rv_pkg: shared constants and fetch-state encoding for the mini RISC-V fetch path
package rv_pkg;
   localparam logic [31:0] RV_EBREAK = 32'h0010_0073;
   localparam logic [31:0] RV_NOP    = 32'h0000_0013;
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HALT  = 2'd1,
      ERR   = 2'd2
   } fetch_state_e;
endpackage

// File: rtl/rv_ifetch_if.sv
// rv_ifetch_if: fetch-unit bus bundle (imem port, decode handshake, redirect, status)
//   master = fetch unit: drives imem_addr, inst_valid/data/pc, halted, misalign_err
//   slave  = environment: drives imem_rdata, inst_ready, redirect_valid/pc
interface rv_ifetch_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halted;
   logic        misalign_err;
   modport master (
      output imem_addr, inst_valid, inst_data, inst_pc, halted, misalign_err,
      input  imem_rdata, inst_ready, redirect_valid, redirect_pc
   );
   modport slave (
      input  imem_addr, inst_valid, inst_data, inst_pc, halted, misalign_err,
      output imem_rdata, inst_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/rv_fetch_fifo.sv
// rv_fetch_fifo: synchronous prefetch FIFO with flush, async active-high reset
//   i_push/i_data write at tail, i_pop advances head, i_flush empties (wins over push/pop)
//   o_count = occupancy, o_head = entry at head (valid when o_count != 0)
module rv_fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  logic [WIDTH-1:0]         i_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic [WIDTH-1:0]         o_head
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [CW-1:0]    r_count;
   // Pointers wrap naturally because DEPTH is a power of two; a push into a
   // full FIFO only happens alongside a pop, so it overwrites the departing head.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= r_wr + 1'b1;
         end
         if (i_pop) r_rd <= r_rd + 1'b1;
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd];
endmodule

// File: rtl/rv_ifetch.sv
// rv_ifetch: instruction-fetch initiator with prefetch FIFO, redirect and EBREAK halt
//   clk, rst (async active-high), bus (rv_ifetch_if.master): imem address/data,
//   decode valid/ready with inst_data/inst_pc, redirect_valid/pc, halted, misalign_err
module rv_ifetch
   import rv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input logic         clk,
   input logic         rst,
   rv_ifetch_if.master bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   fetch_state_e  r_state;
   fetch_state_e  w_state_nxt;
   logic [31:0]   r_pc;
   logic [31:0]   w_pc_nxt;
   logic [CW-1:0] w_count;
   logic [63:0]   w_head;
   logic          w_redirect;
   logic          w_aligned;
   logic          w_pop;
   logic          w_push;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= FETCH;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      if (w_redirect) begin
         w_state_nxt = w_aligned ? FETCH : ERR;
         w_pc_nxt    = w_aligned ? bus.redirect_pc : r_pc;
      end else if (w_push) begin
         w_pc_nxt = r_pc + 32'd4;
         if (bus.imem_rdata == RV_EBREAK) w_state_nxt = HALT;
      end
   end
   // ERR is sticky until reset, so redirects there are masked entirely.
   always_comb begin
      w_redirect = bus.redirect_valid && (r_state != ERR);
      w_aligned  = bus.redirect_pc[1:0] == 2'b00;
      w_pop      = (w_count != '0) && bus.inst_ready;
      w_push     = (r_state == FETCH) && !w_redirect && ((w_count < CW'(DEPTH)) || w_pop);
   end
   rv_fetch_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_redirect),
      .i_data  ({r_pc, bus.imem_rdata}),
      .o_count (w_count),
      .o_head  (w_head)
   );
   assign bus.imem_addr    = r_pc;
   assign bus.inst_valid   = w_count != '0;
   assign bus.inst_pc      = w_head[63:32];
   assign bus.inst_data    = w_head[31:0];
   assign bus.halted       = (r_state == HALT) && (w_count == '0);
   assign bus.misalign_err = r_state == ERR;
endmodule

// File: tb/tb_rv_ifetch.sv
// tb_rv_ifetch: directed self-checking bench for rv_ifetch
module tb_rv_ifetch;
   import rv_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] prog [6] = '{32'h001000B7, 32'h0000A087, 32'h0040A107,
                             32'h102081D3, 32'h0030A427, 32'h00100073};
   rv_ifetch_if bus();
   rv_ifetch #(.RESET_PC(32'h0), .DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [31:0] imem(input logic [31:0] a);
      case (a)
         32'h00:  return 32'h001000B7;
         32'h04:  return 32'h0000A087;
         32'h08:  return 32'h0040A107;
         32'h0C:  return 32'h102081D3;
         32'h10:  return 32'h0030A427;
         32'h14:  return 32'h00100073;
         default: return RV_NOP;
      endcase
   endfunction
   assign bus.imem_rdata = imem(bus.imem_addr);

   task automatic test_reset();
      rst = 1'b1;
      bus.inst_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.inst_valid !== 1'b0 || bus.halted !== 1'b0 || bus.misalign_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: valid=%b halted=%b err=%b want 0/0/0", bus.inst_valid, bus.halted, bus.misalign_err);
      end
      checks++;
      if (bus.imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_addr: got %h want 00000000", bus.imem_addr);
      end
      checks++;
      if (bus.inst_data !== 32'h0 || bus.inst_pc !== 32'h0) begin
         errors++;
         $display("FAIL reset_head: data=%h pc=%h want 0/0", bus.inst_data, bus.inst_pc);
      end
   endtask

   task automatic test_program();
      bus.inst_ready = 1'b1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * i) || bus.inst_data !== prog[i] || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL prog_%0d: v=%b pc=%h data=%h h=%b want 1/%h/%h/0", i, bus.inst_valid, bus.inst_pc, bus.inst_data, bus.halted, 4 * i, prog[i]);
         end
      end
      @(negedge clk);
      checks++;
      if (bus.inst_valid !== 1'b0 || bus.halted !== 1'b1 || bus.imem_addr !== 32'h18) begin
         errors++;
         $display("FAIL prog_halt: v=%b h=%b addr=%h want 0/1/00000018", bus.inst_valid, bus.halted, bus.imem_addr);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h18) begin
         errors++;
         $display("FAIL prog_stay: v=%b addr=%h want 0/00000018", bus.inst_valid, bus.imem_addr);
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.halted !== 1'b0 || bus.imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL async_halted: h=%b addr=%h want 0/00000000", bus.halted, bus.imem_addr);
      end
      bus.inst_ready = 1'b1;
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * i)) begin
            errors++;
            $display("FAIL async_resume_%0d: v=%b pc=%h want 1/%h", i, bus.inst_valid, bus.inst_pc, 4 * i);
         end
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.inst_valid !== 1'b0 || bus.halted !== 1'b0 || bus.misalign_err !== 1'b0) begin
         errors++;
         $display("FAIL async_midstream: v=%b h=%b e=%b want 0/0/0", bus.inst_valid, bus.halted, bus.misalign_err);
      end
   endtask

   task automatic test_backpressure();
      bus.inst_ready = 1'b0;
      @(negedge clk) rst = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.imem_addr !== 32'h08) begin
         errors++;
         $display("FAIL bp_full: v=%b pc=%h addr=%h want 1/00000000/00000008", bus.inst_valid, bus.inst_pc, bus.imem_addr);
      end
      bus.inst_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * i) || bus.inst_data !== prog[i]) begin
            errors++;
            $display("FAIL bp_pop_%0d: v=%b pc=%h data=%h want 1/%h/%h", i, bus.inst_valid, bus.inst_pc, bus.inst_data, 4 * i, prog[i]);
         end
      end
   endtask

   task automatic test_redirect_full();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0C;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      checks++;
      if (bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h0C) begin
         errors++;
         $display("FAIL redir_flush: v=%b addr=%h want 0/0000000c", bus.inst_valid, bus.imem_addr);
      end
      @(negedge clk);
      checks++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0C || bus.inst_data !== 32'h102081D3) begin
         errors++;
         $display("FAIL redir_first: v=%b pc=%h data=%h want 1/0000000c/102081d3", bus.inst_valid, bus.inst_pc, bus.inst_data);
      end
      @(negedge clk);
      checks++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h10 || bus.inst_data !== 32'h0030A427) begin
         errors++;
         $display("FAIL redir_second: v=%b pc=%h data=%h want 1/00000010/0030a427", bus.inst_valid, bus.inst_pc, bus.inst_data);
      end
   endtask

   task automatic test_halt_redirect();
      @(negedge clk);
      checks++;
      if (bus.inst_pc !== 32'h14 || bus.inst_data !== RV_EBREAK || bus.halted !== 1'b0) begin
         errors++;
         $display("FAIL hr_ebreak: pc=%h data=%h h=%b want 00000014/00100073/0", bus.inst_pc, bus.inst_data, bus.halted);
      end
      @(negedge clk);
      checks++;
      if (bus.halted !== 1'b1) begin
         errors++;
         $display("FAIL hr_halted: got %b want 1", bus.halted);
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h04;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      checks++;
      if (bus.halted !== 1'b0 || bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h04) begin
         errors++;
         $display("FAIL hr_exit: h=%b v=%b addr=%h want 0/0/00000004", bus.halted, bus.inst_valid, bus.imem_addr);
      end
      for (int i = 1; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(4 * i) || bus.inst_data !== prog[i]) begin
            errors++;
            $display("FAIL hr_refetch_%0d: v=%b pc=%h data=%h want 1/%h/%h", i, bus.inst_valid, bus.inst_pc, bus.inst_data, 4 * i, prog[i]);
         end
      end
      @(negedge clk);
      checks++;
      if (bus.halted !== 1'b1 || bus.inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL hr_rehalt: h=%b v=%b want 1/0", bus.halted, bus.inst_valid);
      end
   endtask

   task automatic test_misalign();
      bus.inst_ready = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      repeat (3) @(negedge clk);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h06;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      checks++;
      if (bus.misalign_err !== 1'b1 || bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h08) begin
         errors++;
         $display("FAIL mis_enter: e=%b v=%b addr=%h want 1/0/00000008", bus.misalign_err, bus.inst_valid, bus.imem_addr);
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h00;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.misalign_err !== 1'b1 || bus.inst_valid !== 1'b0 || bus.imem_addr !== 32'h08) begin
         errors++;
         $display("FAIL mis_ignore: e=%b v=%b addr=%h want 1/0/00000008", bus.misalign_err, bus.inst_valid, bus.imem_addr);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.misalign_err !== 1'b0) begin
         errors++;
         $display("FAIL mis_async_clear: got %b want 0", bus.misalign_err);
      end
      bus.inst_ready = 1'b1;
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst_data !== 32'h001000B7 || bus.misalign_err !== 1'b0) begin
         errors++;
         $display("FAIL mis_resume: v=%b pc=%h data=%h e=%b want 1/00000000/001000b7/0", bus.inst_valid, bus.inst_pc, bus.inst_data, bus.misalign_err);
      end
   endtask

   initial begin
      test_reset();
      test_program();
      test_async_reset();
      test_backpressure();
      test_redirect_full();
      test_halt_redirect();
      test_misalign();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
